// File: rtl/rd_fifo_checker.sv
// rd_fifo_checker: drains a full byte FIFO and checks an incrementing pattern.
// Optional macro RD_ERR_HALT_EN: stop reading at the first mismatch.
module rd_fifo_checker #(
   parameter int DATA_W  = 8,
   parameter int ERR_W   = 16,
   parameter int BURST_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdfull,
   input  logic               rdempty,
   input  logic [DATA_W-1:0]  q,
   output logic               rdreq,
   output logic [DATA_W-1:0]  data_out,
   output logic               data_vld,
   output logic               err,
   output logic [ERR_W-1:0]   err_cnt,
   output logic               burst_done,
   output logic [BURST_W-1:0] burst_cnt
);

`ifdef RD_ERR_HALT_EN
   typedef enum logic [1:0] {IDLE, READ, DRAIN, HALT} state_t;
`else
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
`endif

   state_t            state;
   logic              rd_vld;
   logic [DATA_W-1:0] expected;
   logic              halted;
   logic              live;
   logic              miss;

`ifdef RD_ERR_HALT_EN
   assign halted = (state == HALT);
`else
   assign halted = 1'b0;
`endif

   // Words arriving while halted are dropped silently.
   assign live  = rd_vld && !halted;
   assign miss  = live && (q != expected);
   assign rdreq = (state == READ) && !rdempty;

   // Burst sequencing: wait for full, drain to empty, flush the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         burst_done <= 1'b0;
         burst_cnt  <= '0;
      end else begin
         burst_done <= 1'b0;
`ifdef RD_ERR_HALT_EN
         if (miss) state <= HALT;
         else
`endif
         case (state)
            IDLE: begin
               if (rdfull) state <= READ;
            end
            READ: begin
               if (rdempty) state <= DRAIN;
            end
            DRAIN: begin
               burst_done <= 1'b1;
               burst_cnt  <= burst_cnt + 1'b1;
               state      <= IDLE;
            end
`ifdef RD_ERR_HALT_EN
            HALT: state <= HALT;
`endif
            default: state <= IDLE;
         endcase
      end
   end

   // Read pipeline, output register and pattern check.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld   <= 1'b0;
         data_out <= '0;
         data_vld <= 1'b0;
         err      <= 1'b0;
         err_cnt  <= '0;
         expected <= '0;
      end else begin
         rd_vld   <= rdreq;
         data_vld <= live;
         err      <= miss;
         if (live) data_out <= q;
         if (miss && (err_cnt != {ERR_W{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
         if (rd_vld)
            expected <= expected + 1'b1;
         else if ((state == IDLE) && rdfull)
            expected <= '0;
      end
   end

endmodule

// File: tb/tb_rd_fifo_checker.sv
// tb_rd_fifo_checker: FIFO model plus scoreboard of expected words.
// Built with ERR_W=4 so err_cnt saturation is reachable quickly.
module tb_rd_fifo_checker;

   localparam int ERR_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             rdfull;
   logic             rdempty;
   logic [7:0]       q = '0;
   logic             rdreq;
   logic [7:0]       data_out;
   logic             data_vld;
   logic             err;
   logic [ERR_W-1:0] err_cnt;
   logic             burst_done;
   logic [15:0]      burst_cnt;

   rd_fifo_checker #(.DATA_W(8), .ERR_W(ERR_W), .BURST_W(16)) dut (
      .clk(clk), .rst(rst), .rdfull(rdfull), .rdempty(rdempty),
      .q(q), .rdreq(rdreq), .data_out(data_out), .data_vld(data_vld),
      .err(err), .err_cnt(err_cnt), .burst_done(burst_done),
      .burst_cnt(burst_cnt)
   );

   always #5 clk = ~clk;

   // FIFO model: 256 deep, one-cycle read latency
   logic [7:0]  mem [256];
   int unsigned wr_total = 0;
   int unsigned rd_total = 0;
   logic        fifo_clr = 1'b0;
   logic        force_full = 1'b0;

   assign rdempty = (wr_total == rd_total);
   assign rdfull  = ((wr_total - rd_total) == 256) || force_full;

   always @(posedge clk) begin
      if (fifo_clr) rd_total <= wr_total;
      else if (rdreq) begin
         q        <= mem[rd_total[7:0]];
         rd_total <= rd_total + 1;
      end
   end

   typedef struct packed {
      logic [7:0] d;
      logic       e;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   vld_total = 0;
   int   bd_seen = 0;
   int   model_errs = 0;
   int   model_bursts = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (data_vld) begin
            vld_total++;
            if (exp_q.size() == 0) chk("extra_vld", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("data_out", {24'd0, data_out}, {24'd0, e.d});
               chk("err", {31'd0, err}, {31'd0, e.e});
            end
         end else begin
            chk("err_no_vld", {31'd0, err}, 0);
         end
         if (burst_done) bd_seen++;
         chk("rdreq_empty", {31'd0, rdreq && rdempty}, 0);
      end
   end

   // push one word; pos is its position within the burst
   task automatic push(input logic [7:0] w, input int pos);
      exp_t e;
      while ((wr_total - rd_total) >= 256) @(negedge clk);
      mem[wr_total[7:0]] = w;
      wr_total++;
      e.d = w;
      e.e = (w != 8'(pos));
      if (e.e) model_errs++;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic wait_burst();
      int base = bd_seen;
      int n = 0;
      while (bd_seen == base && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (bd_seen == base) chk("burst_timeout", 0, 1);
      model_bursts++;
      repeat (4) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      chk("burst_cnt", {16'd0, burst_cnt}, model_bursts);
      chk("err_cnt", {28'd0, err_cnt},
          (model_errs > 15) ? 15 : model_errs);
      chk("rdreq_idle", {31'd0, rdreq}, 0);
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_data_out"}, {24'd0, data_out}, 0);
      chk({tag, "_data_vld"}, {31'd0, data_vld}, 0);
      chk({tag, "_err"}, {31'd0, err}, 0);
      chk({tag, "_err_cnt"}, {28'd0, err_cnt}, 0);
      chk({tag, "_burst_done"}, {31'd0, burst_done}, 0);
      chk({tag, "_burst_cnt"}, {16'd0, burst_cnt}, 0);
      chk({tag, "_rdreq"}, {31'd0, rdreq}, 0);
   endtask

   initial begin
      int base;
      int n;
      logic [7:0] w;

      // reset state
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // clean burst 0..255, then a second one back to back
      for (int i = 0; i < 256; i++) push(8'(i), i);
      wait_burst();
      for (int i = 0; i < 256; i++) push(8'(i), i);
      wait_burst();

      // single corrupted word at position 100
      for (int i = 0; i < 256; i++)
         push((i == 100) ? 8'hAA : 8'(i), i);
      wait_burst();

      // 300 words through the FIFO, pattern wraps at 255
      for (int i = 0; i < 300; i++) push(8'(i), i);
      wait_burst();

      // full and empty together: burst with no data
      force_full = 1'b1;
      @(negedge clk);
      force_full = 1'b0;
      wait_burst();

      // random corruption
      for (int i = 0; i < 256; i++) begin
         w = 8'(i);
         if ($urandom_range(0, 7) == 0)
            w = 8'(i) + 8'($urandom_range(1, 255));
         push(w, i);
      end
      wait_burst();

      // 20 bad words: err_cnt must sit at 15
      for (int i = 0; i < 256; i++)
         push((i < 20) ? (8'(i) ^ 8'h5A) : 8'(i), i);
      wait_burst();
      chk("err_sat", {28'd0, err_cnt}, 15);

      // reset at word 50 of a burst
      for (int i = 0; i < 256; i++) push(8'(i), i);
      base = vld_total;
      n = 0;
      while (vld_total < base + 50 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (vld_total < base + 50) chk("rst_wait_timeout", 0, 1);
      #2;
      rst = 1'b1;
      fifo_clr = 1'b1;
      exp_q.delete();
      #1;
      check_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      fifo_clr = 1'b0;
      model_errs = 0;
      model_bursts = 0;
      @(negedge clk);

      // fresh burst after reset starts from 0
      for (int i = 0; i < 256; i++) push(8'(i), i);
      wait_burst();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
